// File: rtl/pcie_pkg.sv
// Shared constants for the round-robin PCIe virtual-channel arbiter:
// FSM state encodings, channel count and destination-field width.
package pcie_pkg;

  localparam int N_VC   = 4;
  localparam int DEST_W = 2;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ARB   = 2'b01;
  localparam logic [1:0] ST_DRAIN = 2'b10;

  function automatic logic [N_VC-1:0] dec_onehot(input logic [DEST_W-1:0] d);
    return {{(N_VC-1){1'b0}}, 1'b1} << d;
  endfunction

endpackage

// File: rtl/rr_prioridad4.sv
// Combinational 4-way rotating-priority encoder: the first request found
// scanning from i_ptr upward (mod 4) wins a one-hot grant.
module rr_prioridad4
  import pcie_pkg::*;
(
  input  logic [N_VC-1:0]   i_req,
  input  logic [DEST_W-1:0] i_ptr,
  output logic [N_VC-1:0]   o_gnt,
  output logic              o_any
);

  logic [DEST_W-1:0] w_idx;

  always_comb begin
    o_gnt = '0;
    o_any = 1'b0;
    w_idx = '0;
    for (int k = 0; k < N_VC; k++) begin
      // 2-bit addition wraps naturally past input 3 back to input 0
      w_idx = i_ptr + DEST_W'(k);
      if (i_req[w_idx] && !o_any) begin
        o_gnt[w_idx] = 1'b1;
        o_any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr_pcie.sv
// Round-robin scheduler from 4 FWFT input FIFOs to destination FIFOs 4..7.
// Optional per-destination push counters are built when CONTADORES_EN is defined.
module arbitro_rr_pcie
  import pcie_pkg::*;
#(
  parameter int TAMANO_DATOS = 12,
  parameter int DEST_LSB     = 8
`ifdef CONTADORES_EN
  ,
  parameter int ANCHO_CUENTA = 5
`endif
)(
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    activo,
  input  logic [N_VC-1:0]         empty_in,
  input  logic [TAMANO_DATOS-1:0] data_in0,
  input  logic [TAMANO_DATOS-1:0] data_in1,
  input  logic [TAMANO_DATOS-1:0] data_in2,
  input  logic [TAMANO_DATOS-1:0] data_in3,
  input  logic [N_VC-1:0]         almost_full_out,
  output logic [N_VC-1:0]         pop_in,
  output logic [N_VC-1:0]         push_out,
  output logic [TAMANO_DATOS-1:0] data_out,
`ifdef CONTADORES_EN
  input  logic                    req,
  input  logic [DEST_W-1:0]       idx,
  output logic [ANCHO_CUENTA-1:0] cuenta,
  output logic                    valid_cuenta,
`endif
  output logic                    idle
);

  logic [TAMANO_DATOS-1:0] w_data [N_VC];
  logic [DEST_W-1:0]       w_dest [N_VC];
  logic [N_VC-1:0]         w_elig;
  logic [N_VC-1:0]         w_gnt;
  logic                    w_any;
  logic [DEST_W-1:0]       w_gidx;
  logic [1:0]              w_next;

  logic [N_VC-1:0]         r_push;
  logic [TAMANO_DATOS-1:0] r_data;
  logic                    r_idle;
  logic [DEST_W-1:0]       r_ptr;
  logic [1:0]              r_state;

  assign w_data[0] = data_in0;
  assign w_data[1] = data_in1;
  assign w_data[2] = data_in2;
  assign w_data[3] = data_in3;

  // A blocked head only masks its own input, so others can still be served
  always_comb begin
    for (int i = 0; i < N_VC; i++) begin
      w_dest[i] = w_data[i][DEST_LSB +: DEST_W];
      w_elig[i] = activo && !empty_in[i] && !almost_full_out[w_dest[i]];
    end
  end

  rr_prioridad4 u_prio (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_any (w_any)
  );

  always_comb begin
    w_gidx = '0;
    for (int k = 0; k < N_VC; k++) begin
      if (w_gnt[k]) w_gidx = DEST_W'(k);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = w_any ? ST_ARB : ST_IDLE;
      ST_ARB: begin
        if (w_any)          w_next = ST_ARB;
        else if (|r_push)   w_next = ST_DRAIN;
        else                w_next = ST_IDLE;
      end
      ST_DRAIN: w_next = w_any ? ST_ARB : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Reset drops any pending push; the word was already popped upstream
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_push  <= '0;
      r_data  <= '0;
      r_idle  <= 1'b1;
      r_ptr   <= '0;
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
      r_idle  <= (w_next == ST_IDLE) && (&empty_in);
      if (w_any) begin
        r_push <= dec_onehot(w_dest[w_gidx]);
        r_data <= w_data[w_gidx];
        r_ptr  <= w_gidx + 2'd1;
      end else begin
        r_push <= '0;
      end
    end
  end

  assign pop_in   = reset_L ? w_gnt : '0;
  assign push_out = r_push;
  assign data_out = r_data;
  assign idle     = r_idle;

`ifdef CONTADORES_EN
  logic [ANCHO_CUENTA-1:0] r_cnt [N_VC];
  logic [ANCHO_CUENTA-1:0] r_cuenta;
  logic                    r_valid;

  // Registered read samples the counter before this edge's increment
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      for (int d = 0; d < N_VC; d++) r_cnt[d] <= '0;
      r_cuenta <= '0;
      r_valid  <= 1'b0;
    end else begin
      for (int d = 0; d < N_VC; d++) begin
        if (r_push[d]) r_cnt[d] <= r_cnt[d] + 1'b1;
      end
      r_valid  <= req;
      r_cuenta <= req ? r_cnt[idx] : '0;
    end
  end

  assign cuenta       = r_cuenta;
  assign valid_cuenta = r_valid;
`endif

endmodule
